pci_arbiter: RTL

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arbiter_if.sv | 29 ++
 rtl/pci_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pci_arbiter_if.sv
// Bus-side signal bundle for pci_arbiter.
// master: the arbiter's view (samples requests and bus activity, drives grants).
// slave:  the agents/bus view (drives requests and bus activity, sees grants).
interface pci_arbiter_if;
  logic [3:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [3:0] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (
    input  req_n,
    input  frame_n,
    input  irdy_n,
    output gnt_n,
    output gnt_idx,
    output gnt_valid
  );

  modport slave (
    output req_n,
    output frame_n,
    output irdy_n,
    input  gnt_n,
    input  gnt_idx,
    input  gnt_valid
  );
endinterface

// File: rtl/pci_arbiter.sv
// Four-agent round-robin PCI bus arbiter with grant timeout.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
//
// Handshake: an agent holds its req_n bit low for as long as it wants the bus.
// A grant (gnt_n bit low, gnt_valid high) is an offer; the agent accepts it by
// driving frame_n low while granted. An offer not taken within TIMEOUT cycles,
// or withdrawn by the agent raising req_n, is revoked. gnt_n always passes
// through an all-high cycle between two different grantees.
module pci_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  pci_arbiter_if.master     bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } state_t;

  state_t      state_q, state_nx;
  logic [3:0]  gnt_n_q, gnt_n_nx;
  logic [1:0]  idx_q, idx_nx;
  logic        valid_q, valid_nx;
  logic [7:0]  cnt_q, cnt_nx;
  logic [1:0]  last_q, last_nx;

  logic        any_req;
  logic [1:0]  win;
  logic [1:0]  cand;
  logic        bus_idle;
  logic        parked;

  assign bus_idle      = bus.frame_n & bus.irdy_n;
  assign parked        = (state_q == IDLE) && (gnt_n_q != 4'b1111);
  assign bus.gnt_n     = gnt_n_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign dbg_state     = state_q;

  // Round-robin search starting just after the last owner, wrapping 3->0.
  always_comb begin
    any_req = 1'b0;
    win     = last_q;
    cand    = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!any_req && !bus.req_n[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx = state_q;
    gnt_n_nx = gnt_n_q;
    idx_nx   = idx_q;
    valid_nx = valid_q;
    cnt_nx   = cnt_q;
    last_nx  = last_q;
    case (state_q)
      IDLE: begin
        if (!bus.frame_n) begin
          // Another master owns the bus: hands off until it goes idle.
          gnt_n_nx = 4'b1111;
          valid_nx = 1'b0;
        end else if (any_req) begin
`ifdef PCI_ARB_PARK_EN
          if (parked && (win != last_q)) begin
            // Drop the park for one cycle before handing over.
            gnt_n_nx = 4'b1111;
            valid_nx = 1'b0;
          end else begin
            gnt_n_nx = ~(4'b0001 << win);
            idx_nx   = win;
            valid_nx = 1'b1;
            cnt_nx   = 8'd0;
            state_nx = GRANTED;
          end
`else
          gnt_n_nx = ~(4'b0001 << win);
          idx_nx   = win;
          valid_nx = 1'b1;
          cnt_nx   = 8'd0;
          state_nx = GRANTED;
`endif
        end else begin
`ifdef PCI_ARB_PARK_EN
          if (bus_idle) begin
            gnt_n_nx = ~(4'b0001 << last_q);
            idx_nx   = last_q;
          end else begin
            gnt_n_nx = 4'b1111;
          end
          valid_nx = 1'b0;
`else
          gnt_n_nx = 4'b1111;
          valid_nx = 1'b0;
`endif
        end
      end
      GRANTED: begin
        if (!bus.frame_n) begin
          // Transaction started; frame_n beats a simultaneous timeout.
          state_nx = BUSY;
          last_nx  = idx_q;
        end else if (bus.req_n[idx_q]) begin
          // Owner withdrew its request; priority order is left untouched.
          gnt_n_nx = 4'b1111;
          valid_nx = 1'b0;
          idx_nx   = last_q;
          state_nx = IDLE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Grant ignored too long: revoke and send the owner to the back.
          gnt_n_nx = 4'b1111;
          valid_nx = 1'b0;
          last_nx  = idx_q;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      BUSY: begin
        if (bus.frame_n) begin
          // Final data phase seen: grant goes away, wait for the bus to idle.
          gnt_n_nx = 4'b1111;
          valid_nx = 1'b0;
          if (bus_idle) state_nx = IDLE;
        end
      end
      default: begin
        gnt_n_nx = 4'b1111;
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_n_q <= 4'b1111;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_nx;
      gnt_n_q <= gnt_n_nx;
      idx_q   <= idx_nx;
      valid_q <= valid_nx;
      cnt_q   <= cnt_nx;
      last_q  <= last_nx;
    end
  end

endmodule
